wb_register_file: RTL and testbench

Write-back stage plus architectural register file: the consumer end of the MEM/WB pipeline register. Each cycle it takes the MEM/WB outputs, selects the write-back value (ALU / memory / HI / LO), resolves the MOVN/MOVZ-style conditional write, and commits it into a 32×32 register file. The decode stage reads this file through two asynchronous read ports. A retired-write counter is kept for debug/perf.

---
 rtl/wb_register_file.sv | 109 ++++++++++
 tb/tb_wb_register_file.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// Write-back stage and 32-entry architectural register file with a retired-write counter.
// Optional macro WB_BYPASS_EN enables write-first bypass on both asynchronous read ports.
module wb_register_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   RegWriteIn,
  input  logic                   MoveNotZeroIn,
  input  logic                   DontMoveIn,
  input  logic                   HiOrLoIn,
  input  logic                   MemToRegIn,
  input  logic                   HiLoToRegIn,
  input  logic [DATA_WIDTH-1:0]  RHiIn,
  input  logic [DATA_WIDTH-1:0]  RLoIn,
  input  logic [DATA_WIDTH-1:0]  ZeroIn,
  input  logic [DATA_WIDTH-1:0]  ALUResultIn,
  input  logic [DATA_WIDTH-1:0]  ReadDataIn,
  input  logic [4:0]             WriteAddressIn,
  input  logic [4:0]             ReadRegister1,
  input  logic [4:0]             ReadRegister2,
  output logic [DATA_WIDTH-1:0]  ReadData1,
  output logic [DATA_WIDTH-1:0]  ReadData2,
  output logic [DATA_WIDTH-1:0]  WriteDataOut,
  output logic                   WriteEnableOut,
  output logic [COUNT_WIDTH-1:0] WriteCount
);

  logic [DATA_WIDTH-1:0]  regs_q [32];
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   wb_en;

  // Write-back value select; the HI/LO path takes priority over memory/ALU.
  always_comb begin
    wb_data = ALUResultIn;
    if (HiLoToRegIn) begin
      if (HiOrLoIn) begin
        wb_data = RHiIn;
      end else begin
        wb_data = RLoIn;
      end
    end else if (MemToRegIn) begin
      wb_data = ReadDataIn;
    end else begin
      wb_data = ALUResultIn;
    end
  end

  // Qualified enable: conditional-move resolution, $zero suppression, reset masking.
  always_comb begin
    wb_en = RegWriteIn & ~DontMoveIn & (~MoveNotZeroIn | (ZeroIn != '0))
          & (WriteAddressIn != 5'd0) & ~Reset;
  end

  always_comb begin
    count_d = count_q + COUNT_WIDTH'(1);
  end

  // Register array and retired-write counter; synchronous reset clears everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (wb_en) begin
      regs_q[WriteAddressIn] <= wb_data;
      count_q                <= count_d;
    end else begin
      count_q <= count_q;
    end
  end

  // Read port 1: $zero hardwired, optional same-cycle write-first bypass.
  always_comb begin
    ReadData1 = regs_q[ReadRegister1];
    if (ReadRegister1 == 5'd0) begin
      ReadData1 = '0;
`ifdef WB_BYPASS_EN
    end else if (wb_en && (ReadRegister1 == WriteAddressIn)) begin
      ReadData1 = wb_data;
`endif
    end else begin
      ReadData1 = regs_q[ReadRegister1];
    end
  end

  // Read port 2: same policy as port 1.
  always_comb begin
    ReadData2 = regs_q[ReadRegister2];
    if (ReadRegister2 == 5'd0) begin
      ReadData2 = '0;
`ifdef WB_BYPASS_EN
    end else if (wb_en && (ReadRegister2 == WriteAddressIn)) begin
      ReadData2 = wb_data;
`endif
    end else begin
      ReadData2 = regs_q[ReadRegister2];
    end
  end

  assign WriteDataOut   = wb_data;
  assign WriteEnableOut = wb_en;
  assign WriteCount     = count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Randomized + directed bench for wb_register_file against an array-based reference model.
module tb_wb_register_file;

  logic        Clk = 1'b0;
  logic        Reset, RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn;
  logic [31:0] RHiIn, RLoIn, ZeroIn, ALUResultIn, ReadDataIn;
  logic [4:0]  WriteAddressIn, ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2, WriteDataOut;
  logic        WriteEnableOut;
  logic [15:0] WriteCount;

  int unsigned model_regs [32];
  int unsigned model_count;
  int          n_vec = 0;
  int          n_err = 0;

  wb_register_file dut (
    .Clk(Clk), .Reset(Reset), .RegWriteIn(RegWriteIn), .MoveNotZeroIn(MoveNotZeroIn),
    .DontMoveIn(DontMoveIn), .HiOrLoIn(HiOrLoIn), .MemToRegIn(MemToRegIn),
    .HiLoToRegIn(HiLoToRegIn), .RHiIn(RHiIn), .RLoIn(RLoIn), .ZeroIn(ZeroIn),
    .ALUResultIn(ALUResultIn), .ReadDataIn(ReadDataIn), .WriteAddressIn(WriteAddressIn),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .WriteDataOut(WriteDataOut), .WriteEnableOut(WriteEnableOut),
    .WriteCount(WriteCount)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data();
    if (HiLoToRegIn) return HiOrLoIn ? RHiIn : RLoIn;
    return MemToRegIn ? ReadDataIn : ALUResultIn;
  endfunction

  function automatic logic exp_we();
    if (Reset || !RegWriteIn || DontMoveIn) return 1'b0;
    if (MoveNotZeroIn && ZeroIn == 32'd0) return 1'b0;
    if (WriteAddressIn == 5'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (exp_we() && a == WriteAddressIn) return exp_data();
`endif
    return model_regs[a];
  endfunction

  task automatic idle_inputs();
    Reset = 1'b0; RegWriteIn = 1'b0; MoveNotZeroIn = 1'b0; DontMoveIn = 1'b0;
    HiOrLoIn = 1'b0; MemToRegIn = 1'b0; HiLoToRegIn = 1'b0;
    RHiIn = 32'd0; RLoIn = 32'd0; ZeroIn = 32'd0; ALUResultIn = 32'd0; ReadDataIn = 32'd0;
    WriteAddressIn = 5'd0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
  endtask

  // Inputs are already set (after a falling edge): check, clock, update model.
  task automatic cycle(input bit do_check);
    logic [31:0] d;
    logic        we;
    #1;
    d  = exp_data();
    we = exp_we();
    if (do_check) begin
      check_eq("wdata", WriteDataOut, d);
      check_eq("wen", {31'd0, WriteEnableOut}, {31'd0, we});
      check_eq("rd1", ReadData1, exp_read(ReadRegister1));
      check_eq("rd2", ReadData2, exp_read(ReadRegister2));
      check_eq("count", {16'd0, WriteCount}, model_count);
    end
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 0;
      model_count = 0;
    end else if (we) begin
      model_regs[WriteAddressIn] = d;
      model_count = (model_count + 1) % 65536;
    end
    @(negedge Clk);
  endtask

  task automatic write_alu(input logic [4:0] a, input logic [31:0] v);
    idle_inputs();
    RegWriteIn = 1'b1; WriteAddressIn = a; ALUResultIn = v; ReadRegister1 = a;
    cycle(1'b1);
  endtask

  task automatic read_back(input string tag, input logic [4:0] a, input logic [31:0] v);
    idle_inputs();
    ReadRegister1 = a; ReadRegister2 = a;
    #1;
    check_eq(tag, ReadData1, v);
    cycle(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 0;
    model_count = 0;
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    idle_inputs();
    cycle(1'b1);
    check_eq("reset_count", {16'd0, WriteCount}, 32'd0);

    // Four select combinations into r3.
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      RegWriteIn = 1'b1; WriteAddressIn = 5'd3;
      ALUResultIn = 32'h11; ReadDataIn = 32'h22; RHiIn = 32'h33; RLoIn = 32'h44;
      MemToRegIn = (k == 1); HiLoToRegIn = (k >= 2); HiOrLoIn = (k == 2);
      cycle(1'b1);
      read_back("sel_r3", 5'd3, 32'h11 * (k + 1));
    end
    check_eq("sel_count", {16'd0, WriteCount}, 32'd4);

    // Conditional move into r7.
    write_alu(5'd7, 32'h0000_0700);
    idle_inputs();
    RegWriteIn = 1'b1; MoveNotZeroIn = 1'b1; ZeroIn = 32'd0;
    WriteAddressIn = 5'd7; ALUResultIn = 32'h7777_0001;
    cycle(1'b1);
    read_back("movn_z0", 5'd7, 32'h0000_0700);
    check_eq("movn_z0_count", {16'd0, WriteCount}, 32'd5);
    idle_inputs();
    RegWriteIn = 1'b1; MoveNotZeroIn = 1'b1; ZeroIn = 32'h1;
    WriteAddressIn = 5'd7; ALUResultIn = 32'h7777_0002;
    cycle(1'b1);
    read_back("movn_z1", 5'd7, 32'h7777_0002);
    idle_inputs();
    RegWriteIn = 1'b1; DontMoveIn = 1'b1; ZeroIn = 32'h5;
    WriteAddressIn = 5'd7; ALUResultIn = 32'h7777_0003;
    cycle(1'b1);
    read_back("dontmove", 5'd7, 32'h7777_0002);
    check_eq("dontmove_count", {16'd0, WriteCount}, 32'd6);

    // $zero stays zero and is not counted.
    write_alu(5'd0, 32'hDEAD_BEEF);
    read_back("r0", 5'd0, 32'd0);
    check_eq("r0_count", {16'd0, WriteCount}, 32'd6);

    // Same-cycle read of the write target.
    write_alu(5'd9, 32'h0000_1234);
    idle_inputs();
    RegWriteIn = 1'b1; WriteAddressIn = 5'd9; ALUResultIn = 32'hCAFE_F00D; ReadRegister1 = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check_eq("bypass", ReadData1, 32'hCAFE_F00D);
`else
    check_eq("bypass", ReadData1, 32'h0000_1234);
`endif
    cycle(1'b1);
    read_back("r9_after", 5'd9, 32'hCAFE_F00D);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      Reset         = ($urandom_range(0, 59) == 0);
      RegWriteIn    = ($urandom_range(0, 3) != 0);
      MoveNotZeroIn = ($urandom_range(0, 3) == 0);
      DontMoveIn    = ($urandom_range(0, 7) == 0);
      HiOrLoIn      = 1'($urandom);
      MemToRegIn    = 1'($urandom);
      HiLoToRegIn   = 1'($urandom);
      RHiIn = $urandom; RLoIn = $urandom; ALUResultIn = $urandom; ReadDataIn = $urandom;
      ZeroIn = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      WriteAddressIn = 5'($urandom);
      ReadRegister1  = ($urandom_range(0, 2) == 0) ? WriteAddressIn : 5'($urandom);
      ReadRegister2  = 5'($urandom);
      cycle(1'b1);
    end

    // Reset clears everything, and a write issued alongside it to r5 is dropped.
    for (int i = 1; i < 32; i++) write_alu(5'(i), $urandom | 32'h1);
    idle_inputs();
    Reset = 1'b1; RegWriteIn = 1'b1; WriteAddressIn = 5'd5; ALUResultIn = 32'h5555_5555;
    #1;
    check_eq("rst_wen", {31'd0, WriteEnableOut}, 32'd0);
    cycle(1'b1);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      check_eq("rst_rd1", ReadData1, 32'd0);
      check_eq("rst_rd2", ReadData2, 32'd0);
    end
    check_eq("rst_cnt", {16'd0, WriteCount}, 32'd0);
    cycle(1'b1);

    // Counter wrap after 0xFFFF + 1 writes.
    for (int n = 0; n < 65535; n++) begin
      idle_inputs();
      RegWriteIn = 1'b1; WriteAddressIn = 5'(1 + (n % 31)); ALUResultIn = n;
      cycle(1'b0);
    end
    idle_inputs();
    #1;
    check_eq("cnt_ffff", {16'd0, WriteCount}, 32'h0000_FFFF);
    write_alu(5'd12, 32'h0BAD_F00D);
    idle_inputs();
    #1;
    check_eq("cnt_wrap", {16'd0, WriteCount}, 32'h0000_0000);
    read_back("wrap_r12", 5'd12, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
